// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port arbiter: FSM state and the response tag
// that tracks an in-flight read through the RAM latency.
package bram_arb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StGnt0 = 2'd1,
      StGnt1 = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic valid;
      logic id;
   } rsp_tag_t;

endpackage

// File: rtl/bram_rsp_pipe.sv
// Response tag shift register, DEPTH stages deep, matching the RAM read latency.
// Asynchronous clear drops every in-flight read.
module bram_rsp_pipe
   import bram_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   input  rsp_tag_t in_tag,
   output rsp_tag_t out_tag
);

   rsp_tag_t stage_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= in_tag;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign out_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin, burst-bounded sharing of one BRAM port between two ready/valid
// clients, with read data steered back to the issuing client.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned DATA_W       = 18,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned MAX_BURST    = 8
) (
   input  logic              clka,
   input  logic              rsta_n,
   input  logic              c0_valid,
   output logic              c0_ready,
   input  logic              c0_we,
   input  logic [ADDR_W-1:0] c0_addr,
   input  logic [DATA_W-1:0] c0_wdata,
   output logic              c0_rvalid,
   output logic [DATA_W-1:0] c0_rdata,
   input  logic              c1_valid,
   output logic              c1_ready,
   input  logic              c1_we,
   input  logic [ADDR_W-1:0] c1_addr,
   input  logic [DATA_W-1:0] c1_wdata,
   output logic              c1_rvalid,
   output logic [DATA_W-1:0] c1_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_regce,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam logic [7:0] BurstLast = 8'(MAX_BURST - 1);

   arb_state_e        state_q, state_d;
   logic              last_q, last_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

   logic     sel;
   logic     acc;
   logic     own_valid, oth_valid;
   logic     burst_end;
   rsp_tag_t pipe_in, pipe_out;

   assign c0_ready  = (state_q == StGnt0);
   assign c1_ready  = (state_q == StGnt1);
   assign sel       = c1_ready;
   assign own_valid = sel ? c1_valid : c0_valid;
   assign oth_valid = sel ? c0_valid : c1_valid;
   assign acc       = (c0_ready & c0_valid) | (c1_ready & c1_valid);
   assign burst_end = acc && (cnt_q == BurstLast);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (c0_valid && c1_valid) begin
               state_d = last_q ? StGnt0 : StGnt1;
            end else if (c0_valid) begin
               state_d = StGnt0;
            end else if (c1_valid) begin
               state_d = StGnt1;
            end
         end
         StGnt0, StGnt1: begin
            // Grant ends on a dropped request or an exhausted burst; an
            // exhausted burst with no competitor simply re-arms the counter.
            if (!own_valid || burst_end) begin
               last_d = sel;
               cnt_d  = '0;
               if (oth_valid) begin
                  state_d = sel ? StGnt0 : StGnt1;
               end else if (!own_valid) begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state_q <= StIdle;
         last_q  <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ram_en    = acc;
   assign ram_we    = acc & (sel ? c1_we : c0_we);
   assign ram_addr  = acc ? (sel ? c1_addr : c0_addr) : addr_q;
   assign ram_din   = acc ? (sel ? c1_wdata : c0_wdata) : din_q;
   assign ram_regce = 1'b1;

   // Address/data hold their last driven values between beats.
   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         addr_q <= '0;
         din_q  <= '0;
      end else if (acc) begin
         addr_q <= ram_addr;
         din_q  <= ram_din;
      end
   end

   assign pipe_in = {acc & ~ram_we, sel};

   bram_rsp_pipe #(
      .DEPTH (READ_LATENCY)
   ) u_rsp_pipe (
      .clk     (clka),
      .rst_n   (rsta_n),
      .in_tag  (pipe_in),
      .out_tag (pipe_out)
   );

   assign c0_rvalid = pipe_out.valid & ~pipe_out.id;
   assign c1_rvalid = pipe_out.valid & pipe_out.id;
   assign c0_rdata  = c0_rvalid ? ram_dout : rdata0_q;
   assign c1_rdata  = c1_rvalid ? ram_dout : rdata1_q;

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         if (c0_rvalid) rdata0_q <= ram_dout;
         if (c1_rvalid) rdata1_q <= ram_dout;
      end
   end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares one port of the true dual-port read-first frame BRAM between two requesters, for example a camera pixel writer and a compare-logic reader. Requests use a ready/valid handshake, with round-robin arbitration and bounded bursts. The block drives the RAM port, tracks the RAM read latency in a tag pipeline, and steers read data back to the issuing client with a valid strobe. One instance sits in front of each RAM port that needs sharing.

## Interface
- ADDR_W, 10: RAM address width (RAM depth is 2^ADDR_W).
- DATA_W, 18: RAM word width.
- READ_LATENCY, 2: RAM read latency in cycles. Legal values are 1 (LOW_LATENCY) or 2 (HIGH_PERFORMANCE).
- MAX_BURST, 8: maximum beats accepted per grant. Range 1..255.

Ports:
- clka  in  1  clock, shared with the RAM.
- rsta_n  in  1  asynchronous active-low reset.
- c0_valid, c1_valid  in  1  client request valid.
- c0_ready, c1_ready  out  1  client request accepted this cycle when valid&ready.
- c0_we, c1_we  in  1  1 = write, 0 = read.
- c0_addr, c1_addr  in  ADDR_W  request address.
- c0_wdata, c1_wdata  in  DATA_W  write data.
- c0_rvalid, c1_rvalid  out  1  read data strobe, one cycle wide.
- c0_rdata, c1_rdata  out  DATA_W  read data, meaningful only when rvalid is high.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM port write enable.
- ram_addr  out  ADDR_W  RAM port address.
- ram_din  out  DATA_W  RAM port write data.
- ram_regce  out  1  RAM output register enable. Constant 1.
- ram_dout  in  DATA_W  RAM port output data.

## Operation
- FSM states are IDLE, GNT0 and GNT1. A 1-bit last-grant pointer `last` resets to 1, so client 0 wins the first contest.
- IDLE:
  - No ready is asserted.
  - If exactly one client is valid, go to that client's GNT state.
  - If both are valid, go to GNT of the client that is not `last`.
- GNTk:
  - ck_ready = 1 and the other client's ready = 0.
  - On each accepted beat: ram_en = 1, ram_we = ck_we, ram_addr = ck_addr, ram_din = ck_wdata. These are combinational from client k.
  - The beat counter increments per accepted beat.
- Leaving GNTk: set `last` = k and clear the counter in every case below.
  - ck_valid low: go to GNT of the other client if it is valid, else IDLE.
  - Counter reaches MAX_BURST: if the other client is valid, go to its GNT. Otherwise stay in GNTk with the counter cleared.
- When no beat is accepted, ram_en = 0, ram_we = 0, and ram_addr/ram_din hold their last values.
- Response pipeline:
  - It is READ_LATENCY stages of {valid, client id}.
  - It is loaded with {accepted & ~we, k} on each cycle and shifts every cycle.
  - Stage out raises ck_rvalid for one cycle, with ck_rdata = ram_dout. The other client's rdata holds its previous value.
- Writes produce no response. Read-first RAM semantics are invisible to clients because the block never reads and writes in the same beat.
- The block provides no ordering guarantee across clients. Per-client responses arrive in issue order.

## Timing
- Reset values while rsta_n = 0: state IDLE, all ready/rvalid = 0, ram_en = ram_we = 0, ram_addr = ram_din = 0, rdata = 0, pipeline cleared, `last` = 1. ram_regce = 1.
- Request to first ready: 1 cycle (IDLE to GNT). Back-to-back bursts with grant handoff have 0 dead cycles.
- Read response: accepted at edge n, rvalid high during cycle n+READ_LATENCY.
- Sustained throughput is 1 beat per cycle.
- Reset mid-burst or mid-read: in-flight reads are dropped and no rvalid is emitted after deassertion. Deassertion is synchronous to clka.
- A client may change addr/we/wdata only after a beat is accepted or while valid is low. Dropping valid without a handshake ends its grant.

## Structure
- A shared package `bram_arb_pkg` holds the state enum {IDLE, GNT0, GNT1} and the response tag typedef {valid, id}.
- One sub-module: `bram_rsp_pipe`, the parameterized READ_LATENCY-deep tag shift register with asynchronous clear.
- The top holds the FSM, the counter, and the port mux.

## Test plan
- Single read, READ_LATENCY = 2, RAM preloaded with addr 5 = 0x2A5: c0 reads 5. Required: c0_ready one cycle after c0_valid; c0_rvalid exactly 2 cycles after acceptance with c0_rdata = 0x2A5; c1_rvalid stays 0.
- Contention from reset, both clients valid continuously, MAX_BURST = 8: 8 c0 beats, then 8 c1 beats, then 8 c0 beats, with no idle cycle between bursts.
- Write then read: c1 writes 0x155 to addr 1023 (wrap-edge address), then reads addr 1023. Required: rdata = 0x155; ram_we high only on the write beat.
- Lone client, MAX_BURST = 1, only c0 valid for 5 beats: c0_ready stays high every cycle and 5 accepted beats occur.
- Reset mid-operation: issue 2 reads, then assert rsta_n = 0 one cycle later. Required: all outputs at reset values immediately; no rvalid after release.
- READ_LATENCY = 1: c0 and c1 reads interleaved. Required: each rvalid arrives 1 cycle after its accepted beat, routed to the correct client.
